// File: rtl/counter_pkg.sv
// Shared constants and helpers for param_updown_counter.
// Optional saturating mode is selected with PARAM_UPDOWN_COUNTER_SAT_EN.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned CLAMP_W = 32;

  // Limit a parallel-load value to the counter's modulus minus one.
  function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] val,
                                                    input logic [CLAMP_W-1:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle between a counter user (master) and the counter (slave).
interface param_updown_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] counter;
  logic             tc;
  logic             wrap;

  modport master (output en, up_dn, load, load_val, input counter, tc, wrap);
  modport slave  (input en, up_dn, load, load_val, output counter, tc, wrap);
endinterface

// File: rtl/counter_next_val.sv
// Combinational next-count, rollover and terminal-count lookahead for one step.
// PARAM_UPDOWN_COUNTER_SAT_EN switches from modular wrap to clamping at the limits.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter logic [WIDTH-1:0] STEP    = WIDTH'(1)
) (
  input  logic [WIDTH-1:0] i_counter,
  input  logic             i_up_dn,
  output logic [WIDTH-1:0] o_next_c,
  output logic             o_wrap_c,
  output logic             o_tc_c
);

  // One guard bit so counter + STEP cannot overflow before the compare.
  localparam int unsigned   EW    = WIDTH + 1;
  localparam logic [EW-1:0] MAX_E = {1'b0, MAX_VAL};
  localparam logic [EW-1:0] STEP_E = {1'b0, STEP};
  localparam logic [EW-1:0] MOD_E = MAX_E + EW'(1);

  logic [EW-1:0] w_cnt;
  logic [EW-1:0] w_sum;
  logic [EW-1:0] w_res;
  logic          w_over;
  logic          w_under;

  assign w_cnt   = {1'b0, i_counter};
  assign w_sum   = w_cnt + STEP_E;
  assign w_over  = (w_sum > MAX_E);
  assign w_under = (w_cnt < STEP_E);

  always_comb begin
    w_res    = w_cnt;
    o_wrap_c = 1'b0;
    o_tc_c   = 1'b0;
    case (i_up_dn)
`ifdef PARAM_UPDOWN_COUNTER_SAT_EN
      DIR_UP: begin
        w_res  = w_over ? MAX_E : w_sum;
        o_tc_c = (i_counter == MAX_VAL);
      end
      DIR_DN: begin
        w_res  = w_under ? '0 : (w_cnt - STEP_E);
        o_tc_c = (i_counter == '0);
      end
`else
      DIR_UP: begin
        w_res    = w_over ? (w_sum - MOD_E) : w_sum;
        o_wrap_c = w_over;
        o_tc_c   = w_over;
      end
      DIR_DN: begin
        w_res    = w_under ? (w_cnt + MOD_E - STEP_E) : (w_cnt - STEP_E);
        o_wrap_c = w_under;
        o_tc_c   = w_under;
      end
`endif
    endcase
  end

  assign o_next_c = WIDTH'(w_res);

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with load, enable, tc lookahead and wrap pulse.
// Define PARAM_UPDOWN_COUNTER_SAT_EN for saturating instead of wrapping behaviour.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter logic [WIDTH-1:0] STEP    = WIDTH'(1)
) (
  input  logic                          clk,
  input  logic                          reset,
  param_updown_counter_if.slave         bus
);

  logic [WIDTH-1:0] r_counter;
  logic             r_wrap;
  logic [WIDTH-1:0] w_counter_d;
  logic             w_wrap_d;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_wrap_nv;
  logic             w_tc_nv;

  counter_next_val #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP    (STEP)
  ) u_next_val (
    .i_counter (r_counter),
    .i_up_dn   (bus.up_dn),
    .o_next_c  (w_next),
    .o_wrap_c  (w_wrap_nv),
    .o_tc_c    (w_tc_nv)
  );

  assign w_load_clamped = WIDTH'(clamp_load(CLAMP_W'(bus.load_val), CLAMP_W'(MAX_VAL)));

  // Load wins over counting; reset is applied in the register stage.
  always_comb begin
    w_counter_d = r_counter;
    w_wrap_d    = 1'b0;
    if (bus.load) begin
      w_counter_d = w_load_clamped;
    end else if (bus.en) begin
      w_counter_d = w_next;
      w_wrap_d    = w_wrap_nv;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_counter <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_counter <= w_counter_d;
      r_wrap    <= w_wrap_d;
    end
  end

  assign bus.counter = r_counter;
  assign bus.wrap    = r_wrap;
  assign bus.tc      = bus.en & w_tc_nv;

endmodule
